// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences a shared ALU and a
// handshaked unified memory, with a bounded-wait timeout and a retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             negetive,
    input  logic             mem_ready,
    output logic             memreq,
    output logic             memwrite,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             wereg,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       aluop,
    output logic [2:0]       extend_func,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_U = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, halted_d;
    logic [1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              retire;
    logic              mem_state;
    logic              mem_wait;
    logic              timeout;
    logic              unused_func7;

    // Only func7[5] (sub) matters for the supported R-type subset.
    assign unused_func7 = ^{func7[6], func7[4:0]};

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign mem_wait  = mem_state && !mem_ready;
    // The MAX_WAIT-th consecutive cycle without mem_ready ends the access.
    assign timeout   = mem_wait && (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 2'b00;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        halted_d    = halted_q;
        fault_d     = fault_q;
        retire      = 1'b0;
        memreq      = 1'b0;
        memwrite    = 1'b0;
        adrsrc      = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        wereg       = 1'b0;
        resultsrc   = 2'b00;
        alusrca     = 2'b00;
        alusrcb     = 2'b00;
        aluop       = ALU_ADD;
        extend_func = EXT_I;

        if (mem_wait) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        // Gating on rst keeps every strobe low for as long as reset is held.
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    memreq    = 1'b1;
                    alusrcb   = 2'b10;
                    resultsrc = 2'b10;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        fault_d  = FLT_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    alusrca     = 2'b01;
                    alusrcb     = 2'b01;
                    extend_func = (op == OP_JAL) ? EXT_J : EXT_B;
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_I:              state_d = S_EXECI;
                        OP_LUI:            state_d = S_LUI;
                        OP_BR:             state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        default: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            fault_d  = FLT_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrca     = 2'b10;
                    alusrcb     = 2'b01;
                    extend_func = (op == OP_STORE) ? EXT_S : EXT_I;
                    state_d     = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    memreq = 1'b1;
                    adrsrc = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (timeout) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        fault_d  = FLT_TIMEOUT;
                    end
                end
                S_MEMWB: begin
                    resultsrc = 2'b01;
                    wereg     = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEMWRITE: begin
                    memreq   = 1'b1;
                    memwrite = 1'b1;
                    adrsrc   = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (timeout) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        fault_d  = FLT_TIMEOUT;
                    end
                end
                S_EXECR: begin
                    alusrca = 2'b10;
                    aluop   = alu_dec(func3, func7[5]);
                    state_d = S_ALUWB;
                end
                S_EXECI: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                    aluop   = alu_dec(func3, 1'b0);
                    state_d = S_ALUWB;
                end
                S_LUI: begin
                    alusrca     = 2'b11;
                    alusrcb     = 2'b01;
                    extend_func = EXT_U;
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    wereg   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    alusrca = 2'b10;
                    aluop   = ALU_SUB;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    case (func3)
                        3'b000:  pcwrite = zero;
                        3'b001:  pcwrite = ~zero;
                        3'b100:  pcwrite = negetive;
                        3'b101:  pcwrite = ~negetive;
                        default: begin
                            retire   = 1'b0;
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            fault_d  = FLT_ILLEGAL;
                        end
                    endcase
                end
                S_JAL, S_JALRPC: begin
                    pcwrite = 1'b1;
                    alusrca = 2'b01;
                    alusrcb = 2'b10;
                    state_d = S_ALUWB;
                end
                S_JALR: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                    state_d = S_JALRPC;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end

        instret_d = instret_q + CNT_W'(retire);
    end

    assign halted  = halted_q;
    assign fault   = fault_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-accurate check of multicycle_controller outputs against hand-derived per-state
// output patterns, driven from a vector table through an expected-value queue.
module tb_multicycle_controller;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_WAIT = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // {memreq,memwrite,adrsrc,irwrite,pcwrite,wereg, resultsrc, alusrca, alusrcb, aluop, extend_func}
    localparam logic [17:0] O_Z    = 18'b0;
    localparam logic [17:0] O_FW   = {6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [17:0] O_FR   = {6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [17:0] O_DB   = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010};
    localparam logic [17:0] O_DJ   = {6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100};
    localparam logic [17:0] O_MAL  = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};
    localparam logic [17:0] O_MAS  = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001};
    localparam logic [17:0] O_MR   = {6'b101000, 12'b0};
    localparam logic [17:0] O_MWB  = {6'b000001, 2'b01, 10'b0};
    localparam logic [17:0] O_MW   = {6'b111000, 12'b0};
    localparam logic [17:0] O_LUI  = {6'b000000, 2'b00, 2'b11, 2'b01, 3'b000, 3'b011};
    localparam logic [17:0] O_WB   = {6'b000001, 12'b0};
    localparam logic [17:0] O_BT   = {6'b000010, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
    localparam logic [17:0] O_BN   = {6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
    localparam logic [17:0] O_JAL  = {6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000};
    localparam logic [17:0] O_JALR = {6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};

    typedef struct {
        string       nm;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        n;
        logic        rdy;
        logic [17:0] ex;
        logic        hlt;
        logic [1:0]  flt;
        logic [3:0]  ir;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       op;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             zero, negetive, mem_ready;
    logic             memreq, memwrite, adrsrc, irwrite, pcwrite, wereg;
    logic [1:0]       resultsrc, alusrca, alusrcb;
    logic [2:0]       aluop, extend_func;
    logic             halted;
    logic [1:0]       fault;
    logic [CNT_W-1:0] instret;

    vec_t       vq[$];
    vec_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    string      cur_nm;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    int         row_idx;

    multicycle_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .negetive(negetive), .mem_ready(mem_ready), .memreq(memreq), .memwrite(memwrite),
        .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .wereg(wereg),
        .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .extend_func(extend_func), .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] er(input logic [2:0] alu);
        er = {6'b000000, 2'b00, 2'b10, 2'b00, alu, 3'b000};
    endfunction

    function automatic logic [17:0] ei(input logic [2:0] alu);
        ei = {6'b000000, 2'b00, 2'b10, 2'b01, alu, 3'b000};
    endfunction

    task automatic ins(input string nm, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7);
        cur_nm  = nm;
        cur_op  = o;
        cur_f3  = f3;
        cur_f7  = f7;
        row_idx = 0;
    endtask

    task automatic row(input logic r, input logic rdy, input logic z, input logic n,
                       input logic [17:0] ex, input logic h, input logic [1:0] f,
                       input logic [3:0] ir);
        vec_t t;
        t.nm  = $sformatf("%s.%0d", cur_nm, row_idx);
        t.rst = r;   t.op = cur_op; t.f3 = cur_f3; t.f7 = cur_f7;
        t.z   = z;   t.n  = n;      t.rdy = rdy;   t.ex = ex;
        t.hlt = h;   t.flt = f;     t.ir = ir;
        vq.push_back(t);
        row_idx++;
    endtask

    task automatic v(input logic rdy, input logic [17:0] ex, input logic [3:0] ir);
        row(1'b1, rdy, 1'b0, 1'b0, ex, 1'b0, 2'b00, ir);
    endtask

    task automatic rst_row();
        ins("reset", 7'd0, 3'd0, 7'd0);
        row(1'b0, 1'b1, 1'b0, 1'b0, O_Z, 1'b0, 2'b00, 4'd0);
    endtask

    // Four-cycle ALU-class instruction: fetch, decode, execute stage, write-back.
    task automatic alu4(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [17:0] ex_stage, input logic [3:0] ir);
        ins(nm, o, f3, f7);
        v(1'b1, O_FR, ir); v(1'b1, O_DB, ir); v(1'b1, ex_stage, ir); v(1'b1, O_WB, ir);
    endtask

    task automatic check(input vec_t e);
        logic [17:0] got;
        got = {memreq, memwrite, adrsrc, irwrite, pcwrite, wereg,
               resultsrc, alusrca, alusrcb, aluop, extend_func};
        n_cmp++;
        if (got !== e.ex || halted !== e.hlt || fault !== e.flt || instret !== e.ir) begin
            n_err++;
            $display("FAIL %s: got out=%b hlt=%b flt=%b instret=%0d, required out=%b hlt=%b flt=%b instret=%0d",
                     e.nm, got, halted, fault, instret, e.ex, e.hlt, e.flt, e.ir);
        end
    endtask

    task automatic run();
        vec_t e;
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst       = vq[i].rst;
            op        = vq[i].op;
            func3     = vq[i].f3;
            func7     = vq[i].f7;
            zero      = vq[i].z;
            negetive  = vq[i].n;
            mem_ready = vq[i].rdy;
            exp_q.push_back(vq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check(e);
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b0; op = '0; func3 = '0; func7 = '0;
        zero = 1'b0; negetive = 1'b0; mem_ready = 1'b0;

        rst_row(); rst_row();
        alu4("addi", OP_I, 3'b000, 7'd0, ei(3'b000), 4'd0);
        alu4("add",  OP_R, 3'b000, 7'd0, er(3'b000), 4'd1);
        ins("lw_wait3", OP_LW, 3'b010, 7'd0);
        v(1, O_FR, 2); v(1, O_DB, 2); v(1, O_MAL, 2);
        v(0, O_MR, 2); v(0, O_MR, 2); v(0, O_MR, 2); v(1, O_MR, 2); v(1, O_MWB, 2);
        ins("sw", OP_SW, 3'b010, 7'd0);
        v(1, O_FR, 3); v(1, O_DB, 3); v(1, O_MAS, 3); v(1, O_MW, 3);
        ins("beq_taken", OP_B, 3'b000, 7'd0);
        v(1, O_FR, 4); v(1, O_DB, 4); row(1, 1, 1, 0, O_BT, 0, 2'b00, 4'd4);
        ins("bne_not", OP_B, 3'b001, 7'd0);
        v(1, O_FR, 5); v(1, O_DB, 5); row(1, 1, 1, 0, O_BN, 0, 2'b00, 4'd5);
        ins("blt_taken", OP_B, 3'b100, 7'd0);
        v(1, O_FR, 6); v(1, O_DB, 6); row(1, 1, 0, 1, O_BT, 0, 2'b00, 4'd6);
        ins("bge_not", OP_B, 3'b101, 7'd0);
        v(1, O_FR, 7); v(1, O_DB, 7); row(1, 1, 0, 1, O_BN, 0, 2'b00, 4'd7);
        ins("jal", OP_JAL, 3'b000, 7'd0);
        v(1, O_FR, 8); v(1, O_DJ, 8); v(1, O_JAL, 8); v(1, O_WB, 8);
        ins("jalr", OP_JALR, 3'b000, 7'd0);
        v(1, O_FR, 9); v(1, O_DB, 9); v(1, O_JALR, 9); v(1, O_JAL, 9); v(1, O_WB, 9);
        alu4("lui",  OP_LUI, 3'b000, 7'd0,        O_LUI,      4'd10);
        alu4("sub",  OP_R,   3'b000, 7'b0100000,  er(3'b001), 4'd11);
        alu4("nosubi", OP_I, 3'b000, 7'b0100000,  ei(3'b000), 4'd12);
        alu4("xor",  OP_R,   3'b100, 7'd0,        er(3'b110), 4'd13);
        alu4("sltui", OP_I,  3'b011, 7'd0,        ei(3'b101), 4'd14);
        ins("fetch_last_wait_ok", OP_I, 3'b111, 7'd0);
        v(0, O_FW, 15); v(0, O_FW, 15); v(0, O_FW, 15); v(1, O_FR, 15);
        v(1, O_DB, 15); v(1, ei(3'b010), 15); v(1, O_WB, 15);
        alu4("or", OP_R, 3'b110, 7'd0, er(3'b011), 4'd0);
        ins("fetch_timeout", OP_I, 3'b000, 7'd0);
        v(0, O_FW, 1); v(0, O_FW, 1); v(0, O_FW, 1); v(0, O_FW, 1);
        for (int i = 0; i < 3; i++) row(1, 1, 1, 1, O_Z, 1, 2'b10, 4'd1);
        run();

        rst_row();
        alu4("addi2", OP_I, 3'b000, 7'd0, ei(3'b000), 4'd0);
        ins("illegal_op", OP_BAD, 3'b000, 7'd0);
        v(1, O_FR, 1); v(1, O_DB, 1);
        for (int i = 0; i < 3; i++) row(1, 1, 1, 1, O_Z, 1, 2'b01, 4'd1);
        rst_row();
        ins("illegal_branch", OP_B, 3'b010, 7'd0);
        v(1, O_FR, 0); v(1, O_DB, 0); row(1, 1, 1, 0, O_BN, 0, 2'b00, 4'd0);
        for (int i = 0; i < 2; i++) row(1, 1, 1, 0, O_Z, 1, 2'b01, 4'd0);
        run();

        rst_row();
        for (int i = 0; i < 17; i++) alu4("wrap_addi", OP_I, 3'b000, 7'd0, ei(3'b000), 4'(i));
        ins("sw_reset", OP_SW, 3'b010, 7'd0);
        v(1, O_FR, 1); v(1, O_DB, 1); v(1, O_MAS, 1); v(0, O_MW, 1);
        run();

        // Reset lands in the middle of a stalled MEMWRITE cycle.
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({memreq, memwrite, irwrite, pcwrite, wereg} !== 5'b0 || instret !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset_midwrite: got strobes=%b instret=%0d, required strobes=00000 instret=0",
                     {memreq, memwrite, irwrite, pcwrite, wereg}, instret);
        end

        ins("after_reset", OP_I, 3'b000, 7'd0);
        v(0, O_FW, 0); v(0, O_FW, 0); v(0, O_FW, 0); v(1, O_FR, 0);
        v(1, O_DB, 0); v(1, ei(3'b000), 0); v(1, O_WB, 0);
        ins("after_reset_next", OP_I, 3'b000, 7'd0);
        v(1, O_FR, 1);
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
